axi_lite_reg_bank: RTL and testbench

Parametrised AXI4-Lite slave register bank. It is the next generation of the fixed 4×32-bit simple register bank. It adds a configurable register count and width, byte strobes, read-only status registers, write-1-to-clear (W1C) event registers with hardware set, and SLVERR responses. It sits behind the block-design AXI interconnect and exposes a flat register vector to user logic.

---
 rtl/axi_lite_reg_pkg.sv | 19 +
 rtl/axi_lite_reg_bank_if.sv | 53 +++++
 rtl/axi_lite_reg_cell.sv | 52 +++++
 rtl/axi_lite_reg_bank.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared constants and elaboration-time helpers for the AXI4-Lite register bank.
package axi_lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of byte-offset bits below the register index in an address.
  function automatic int addr_lsb(input int data_width);
    return clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank slave.
interface axi_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/axi_lite_reg_cell.sv
// One register of the bank: byte-strobe merge, W1C clear with hardware-set priority,
// or read-only bypass of the status input.
module axi_lite_reg_cell
  import axi_lite_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit IS_RO      = 1'b0,
  parameter bit IS_W1C     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0]   hw_in_i,
  input  logic [DATA_WIDTH-1:0]   hw_set_i,
  output logic [DATA_WIDTH-1:0]   q_o,
  output logic [DATA_WIDTH-1:0]   rd_o
);

  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [DATA_WIDTH-1:0] bit_mask;

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      bit_mask[b*8 +: 8] = {8{wstrb_i[b]}};
    end
  end

  // Set is OR-ed in after the clear so a coincident hardware event is never lost.
  always_comb begin
    val_d = val_q;
    if (IS_RO) begin
      val_d = hw_in_i;
    end else if (IS_W1C) begin
      if (we_i) val_d = val_d & ~(wdata_i & bit_mask);
      val_d = val_d | hw_set_i;
    end else if (we_i) begin
      val_d = (val_q & ~bit_mask) | (wdata_i & bit_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q_o  = val_q;
  assign rd_o = IS_RO ? hw_in_i : val_q;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank with byte strobes, read-only status, W1C event
// registers and SLVERR on unmapped or read-only writes.
module axi_lite_reg_bank
  import axi_lite_reg_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi_lite_reg_bank_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  localparam logic W_COLLECT = 1'b0;
  localparam logic W_RESP    = 1'b1;
  localparam logic R_ADDR    = 1'b0;
  localparam logic R_DATA    = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

  logic              wstate_q, wstate_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [IDX_W-1:0]  widx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      widx_c;
  logic [31:0]           widx_ext, ridx_ext;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [STRB_W-1:0]     wstrb_c;
  logic [NUM_REGS-1:0]   wsel, wr_we;
  logic [1:0]            wresp_c;
  logic [DATA_WIDTH-1:0] rd_val [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  rd_hit;

  assign aw_hs = awready_q & s_axi.S_AXI_AWVALID;
  assign w_hs  = wready_q  & s_axi.S_AXI_WVALID;
  assign ar_hs = arready_q & s_axi.S_AXI_ARVALID;

  // Use the captured beat if it arrived earlier, otherwise the one on the bus now.
  assign widx_c  = aw_done_q ? widx_q  : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign wdata_c = w_done_q  ? wdata_q : s_axi.S_AXI_WDATA;
  assign wstrb_c = w_done_q  ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign commit  = (wstate_q == W_COLLECT) & (aw_done_q | aw_hs) & (w_done_q | w_hs);

  assign widx_ext = 32'(widx_c);
  assign ridx_ext = 32'(s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wsel[i]       = (widx_ext == 32'(i));
    assign wr_we[i]      = commit & wsel[i];
    assign wr_pulse_d[i] = wr_we[i] & ~RO_MASK[i];

    axi_lite_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .IS_RO      (RO_MASK[i]),
      .IS_W1C     (W1C_MASK[i] & ~RO_MASK[i])
    ) u_cell (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .we_i     (wr_we[i]),
      .wdata_i  (wdata_c),
      .wstrb_i  (wstrb_c),
      .hw_in_i  (hw_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set_i (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o      (reg_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_o     (rd_val[i])
    );
  end

  assign wresp_c = (|wsel && !(|(wsel & RO_MASK))) ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_COLLECT: begin
        if (commit) begin
          wstate_d  = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wresp_c;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
          awready_d = ~(aw_done_q | aw_hs);
          wready_d  = ~(w_done_q | w_hs);
        end
      end
      default: begin
        if (s_axi.S_AXI_BREADY) begin
          wstate_d  = W_COLLECT;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase
  end

  // Read data for unmapped indices falls out of the mux as zero.
  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx_ext == 32'(i)) begin
        rd_mux = rd_val[i];
        rd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_ADDR: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux;
          rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: begin
        if (s_axi.S_AXI_RREADY) begin
          rstate_d  = R_ADDR;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q   <= W_COLLECT;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rstate_q   <= R_ADDR;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rstate_q   <= rstate_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) widx_q <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    if (w_hs) begin
      wdata_q <= s_axi.S_AXI_WDATA;
      wstrb_q <= s_axi.S_AXI_WSTRB;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign wr_pulse            = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Bench for axi_lite_reg_bank: a plain bank (A) and one with RO reg 2 / W1C reg 3 (B)
// receive identical bus stimulus; checks are taken from the bank selected by 'sel'.
module tb_axi_lite_reg_bank;
  import axi_lite_reg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [NR*DW-1:0] hw_in, hw_set, reg_q_a, reg_q_b;
  logic [NR-1:0]    wr_pulse_a, wr_pulse_b;

  axi_lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
  axi_lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

  assign if_a.S_AXI_AWADDR = awaddr;  assign if_b.S_AXI_AWADDR = awaddr;
  assign if_a.S_AXI_AWPROT = 3'b000;  assign if_b.S_AXI_AWPROT = 3'b000;
  assign if_a.S_AXI_AWVALID = awvalid; assign if_b.S_AXI_AWVALID = awvalid;
  assign if_a.S_AXI_WDATA = wdata;    assign if_b.S_AXI_WDATA = wdata;
  assign if_a.S_AXI_WSTRB = wstrb;    assign if_b.S_AXI_WSTRB = wstrb;
  assign if_a.S_AXI_WVALID = wvalid;  assign if_b.S_AXI_WVALID = wvalid;
  assign if_a.S_AXI_BREADY = bready;  assign if_b.S_AXI_BREADY = bready;
  assign if_a.S_AXI_ARADDR = araddr;  assign if_b.S_AXI_ARADDR = araddr;
  assign if_a.S_AXI_ARPROT = 3'b000;  assign if_b.S_AXI_ARPROT = 3'b000;
  assign if_a.S_AXI_ARVALID = arvalid; assign if_b.S_AXI_ARVALID = arvalid;
  assign if_a.S_AXI_RREADY = rready;  assign if_b.S_AXI_RREADY = rready;

  axi_lite_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                      .RO_MASK(16'h0000), .W1C_MASK(16'h0000)) dut_a (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(if_a), .reg_q(reg_q_a),
    .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse_a));

  axi_lite_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                      .RO_MASK(16'h0004), .W1C_MASK(16'h0008)) dut_b (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(if_b), .reg_q(reg_q_b),
    .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse_b));

  logic awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic [1:0] bresp_s, rresp_s;
  logic [DW-1:0] rdata_s;
  logic [NR*DW-1:0] reg_q_s;
  logic [NR-1:0] wr_pulse_s;
  assign awready_s  = sel ? if_b.S_AXI_AWREADY : if_a.S_AXI_AWREADY;
  assign wready_s   = sel ? if_b.S_AXI_WREADY  : if_a.S_AXI_WREADY;
  assign bvalid_s   = sel ? if_b.S_AXI_BVALID  : if_a.S_AXI_BVALID;
  assign bresp_s    = sel ? if_b.S_AXI_BRESP   : if_a.S_AXI_BRESP;
  assign arready_s  = sel ? if_b.S_AXI_ARREADY : if_a.S_AXI_ARREADY;
  assign rvalid_s   = sel ? if_b.S_AXI_RVALID  : if_a.S_AXI_RVALID;
  assign rresp_s    = sel ? if_b.S_AXI_RRESP   : if_a.S_AXI_RRESP;
  assign rdata_s    = sel ? if_b.S_AXI_RDATA   : if_a.S_AXI_RDATA;
  assign reg_q_s    = sel ? reg_q_b : reg_q_a;
  assign wr_pulse_s = sel ? wr_pulse_b : wr_pulse_a;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NR-1:0] pulse,
                           output logic [NR-1:0] pulse_after);
    int n;
    logic hs_aw, hs_w;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      hs_aw = awvalid && awready_s;
      hs_w  = wvalid && wready_s;
      @(posedge clk); #1; n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid = 1'b0;
    end
    check("wr_accept", {62'd0, awvalid, wvalid}, 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid_s && n < 20) begin @(posedge clk); #1; n++; end
    check("wr_bvalid", 64'(bvalid_s), 64'd1);
    resp = bresp_s;
    pulse = wr_pulse_s;
    @(posedge clk); #1;
    pulse_after = wr_pulse_s;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    int n;
    logic hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arready_s;
      @(posedge clk); #1; n++;
      if (hs) arvalid = 1'b0;
    end
    check("rd_accept", 64'(arvalid), 64'd0);
    arvalid = 1'b0;
    while (!rvalid_s && n < 20) begin @(posedge clk); #1; n++; end
    check("rd_rvalid", 64'(rvalid_s), 64'd1);
    d = rdata_s;
    resp = rresp_s;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    logic          s;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [1:0]    bresp;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    resp, rresp;
    logic [DW-1:0] rd, hold_d;
    logic [NR-1:0] pulse, pulse_after, exp_pulse;
    int            idx, pcount;

    vecs[0] = '{1'b0, 8'h00, 32'h0000_0001, 4'hF, RESP_OKAY,   32'h0000_0001, RESP_OKAY};
    vecs[1] = '{1'b0, 8'h04, 32'h0000_0002, 4'hF, RESP_OKAY,   32'h0000_0002, RESP_OKAY};
    vecs[2] = '{1'b0, 8'h08, 32'h0000_0003, 4'hF, RESP_OKAY,   32'h0000_0003, RESP_OKAY};
    vecs[3] = '{1'b0, 8'h0C, 32'h0000_0004, 4'hF, RESP_OKAY,   32'h0000_0004, RESP_OKAY};
    vecs[4] = '{1'b0, 8'h14, 32'hAABB_CCDD, 4'hF, RESP_OKAY,   32'hAABB_CCDD, RESP_OKAY};
    vecs[5] = '{1'b0, 8'h14, 32'h1122_3344, 4'h5, RESP_OKAY,   32'hAA22_CC44, RESP_OKAY};
    vecs[6] = '{1'b1, 8'h08, 32'h0000_0000, 4'hF, RESP_SLVERR, 32'hCAFE_0001, RESP_OKAY};

    sel = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    hw_in = '0; hw_set = '0;
    hw_in[2*DW +: DW] = 32'hCAFE_0001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {61'd0, awready_s, wready_s, arready_s}, 64'd0);
    check("rst_valid", {62'd0, bvalid_s, rvalid_s}, 64'd0);
    check("rst_regq_a", 64'(|reg_q_a), 64'd0);
    check("rst_regq_b", 64'(|reg_q_b), 64'd0);
    rst_n = 1'b1;
    check("rst_rel_ready", {61'd0, awready_s, wready_s, arready_s}, 64'd0);
    @(posedge clk); #1;
    check("first_edge_ready", {61'd0, awready_s, wready_s, arready_s}, 64'd7);

    // Table: write, check response and strobe, read back, check reg_q
    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].s;
      idx = int'(vecs[v].addr) >> 2;
      axi_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, resp, pulse, pulse_after);
      exp_pulse = (vecs[v].bresp == RESP_OKAY) ? (16'h1 << idx) : 16'h0;
      check($sformatf("v%0d_bresp", v), 64'(resp), 64'(vecs[v].bresp));
      check($sformatf("v%0d_pulse", v), 64'(pulse), 64'(exp_pulse));
      check($sformatf("v%0d_pulse_after", v), 64'(pulse_after), 64'd0);
      axi_read(vecs[v].addr, rd, rresp);
      check($sformatf("v%0d_rdata", v), 64'(rd), 64'(vecs[v].rdata));
      check($sformatf("v%0d_rresp", v), 64'(rresp), 64'(vecs[v].rresp));
      check($sformatf("v%0d_regq", v), 64'(reg_q_s[idx*DW +: DW]), 64'(vecs[v].rdata));
    end

    // W1C register 3 on bank B
    sel = 1'b1;
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, resp, pulse, pulse_after);
    hw_set[3*DW +: DW] = 32'h0000_00F0;
    @(posedge clk); #1;
    hw_set = '0;
    axi_read(8'h0C, rd, rresp);
    check("w1c_set", 64'(rd), 64'h0F0);
    axi_write(8'h0C, 32'h0000_0030, 4'hF, resp, pulse, pulse_after);
    check("w1c_clr_bresp", 64'(resp), 64'(RESP_OKAY));
    axi_read(8'h0C, rd, rresp);
    check("w1c_clr", 64'(rd), 64'h0C0);
    awaddr = 8'h0C; wdata = 32'h0000_0040; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    hw_set[3*DW +: DW] = 32'h0000_0040;
    check("w1c_coll_ready", {62'd0, awready_s, wready_s}, 64'd3);
    @(posedge clk); #1;
    hw_set = '0; awvalid = 1'b0; wvalid = 1'b0;
    check("w1c_coll_bvalid", 64'(bvalid_s), 64'd1);
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(8'h0C, rd, rresp);
    check("w1c_set_wins", 64'(rd), 64'h0C0);

    // Unmapped read, W ahead of AW, back-pressure on B and R (bank A)
    sel = 1'b0;
    axi_read(8'h40, rd, rresp);
    check("oor_rdata", 64'(rd), 64'd0);
    check("oor_rresp", 64'(rresp), 64'(RESP_SLVERR));
    pcount = 0;
    wdata = 32'h0000_0066; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      wvalid = 1'b0;
      pcount += int'(wr_pulse_a[6]);
      check($sformatf("early_w_bvalid%0d", c), 64'(bvalid_s), 64'd0);
      check($sformatf("early_w_wready%0d", c), 64'(wready_s), 64'd0);
    end
    awaddr = 8'h18; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("late_aw_bresp", 64'(bresp_s), 64'(RESP_OKAY));
    for (int c = 0; c < 5; c++) begin
      pcount += int'(wr_pulse_a[6]);
      check($sformatf("bhold_bvalid%0d", c), 64'(bvalid_s), 64'd1);
      check($sformatf("bhold_ready%0d", c), {62'd0, awready_s, wready_s}, 64'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bhold_release", 64'(bvalid_s), 64'd0);
    check("single_commit", 64'(pcount), 64'd1);
    araddr = 8'h18; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    hold_d = rdata_s;
    check("rhold_first", 64'(hold_d), 64'h66);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("rhold_rvalid%0d", c), 64'(rvalid_s), 64'd1);
      check($sformatf("rhold_rdata%0d", c), 64'(rdata_s), 64'h66);
      check($sformatf("rhold_arready%0d", c), 64'(arready_s), 64'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rhold_release", 64'(rvalid_s), 64'd0);

    // Asynchronous reset while BVALID is pending
    awaddr = 8'h04; wdata = 32'h0000_0077; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("arst_pre_bvalid", 64'(bvalid_s), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", 64'(bvalid_s), 64'd0);
    check("arst_ready", {61'd0, awready_s, wready_s, arready_s}, 64'd0);
    check("arst_regq", 64'(|reg_q_a), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_ready", {61'd0, awready_s, wready_s, arready_s}, 64'd7);
    axi_read(8'h14, rd, rresp);
    check("arst_rd_cleared", 64'(rd), 64'd0);
    check("arst_rd_resp", 64'(rresp), 64'(RESP_OKAY));
    axi_write(8'h04, 32'h0000_005A, 4'hF, resp, pulse, pulse_after);
    check("arst_wr_bresp", 64'(resp), 64'(RESP_OKAY));
    axi_read(8'h04, rd, rresp);
    check("arst_wr_readback", 64'(rd), 64'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
